// File: rtl/timer_bank_if.sv
// ============================================================================
// timer_bank_if : load bus and status outputs of timer_bank
// Revision      : 1.0
// ============================================================================
`default_nettype none

interface timer_bank_if #(
   parameter int WIDTH    = 5,
   parameter int CHANNELS = 4,
   parameter int CH_W     = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
);
   logic                      load_valid;
   logic [CH_W-1:0]           load_ch;
   logic [WIDTH-1:0]          load_value;
   logic                      load_mode;
   logic [CHANNELS-1:0]       enable;
   logic [CHANNELS-1:0]       irq_clear;
   logic [CHANNELS-1:0]       trigger;
   logic [CHANNELS-1:0]       irq;
   logic [CHANNELS-1:0]       busy;
   logic [CHANNELS*WIDTH-1:0] count;

   modport master (
      output load_valid, load_ch, load_value, load_mode, enable, irq_clear,
      input  trigger, irq, busy, count
   );

   modport slave (
      input  load_valid, load_ch, load_value, load_mode, enable, irq_clear,
      output trigger, irq, busy, count
   );
endinterface

`default_nettype wire

// File: rtl/timer_bank.sv
// ============================================================================
// timer_bank : bank of one-shot/periodic down-counters sharing a prescaler
// Revision   : 1.0
// ============================================================================
`default_nettype none

module timer_bank #(
   parameter int WIDTH    = 5,
   parameter int CHANNELS = 4,
   parameter int PRESCALE = 1
) (
   input  logic         clk,
   input  logic         reset,
   timer_bank_if.slave  bus
);
   localparam int CH_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
   localparam int PS_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
   localparam logic [CH_W:0]   NUM_CH   = (CH_W+1)'(CHANNELS);
   localparam logic [PS_W-1:0] PS_LAST  = PS_W'(PRESCALE - 1);
   localparam logic [0:0]      IDLE     = 1'b0;
   localparam logic [0:0]      RUN      = 1'b1;

   logic [PS_W-1:0] presc;
   logic            tick;
   logic            load_ok;

   assign tick    = (presc == PS_LAST);
   // The extra MSB lets CHANNELS=2^CH_W be represented so out-of-range
   // indices are rejected for every channel count.
   assign load_ok = bus.load_valid && ({1'b0, bus.load_ch} < NUM_CH);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         presc <= '0;
      end else if (tick) begin
         presc <= '0;
      end else begin
         presc <= presc + PS_W'(1);
      end
   end

   for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
      logic [WIDTH-1:0] cnt;
      logic [WIDTH-1:0] reload;
      logic             mode;
      logic [0:0]       state;
      logic             trig;
      logic             flag;
      logic             hit;
      logic             step;

      assign hit  = load_ok && (bus.load_ch == CH_W'(i));
      assign step = (state == RUN) && tick && bus.enable[i];

      always_ff @(posedge clk or negedge reset) begin
         if (!reset) begin
            cnt    <= '0;
            reload <= '0;
            mode   <= 1'b0;
            state  <= IDLE;
            trig   <= 1'b0;
            flag   <= 1'b0;
         end else begin
            trig <= 1'b0;
            if (bus.irq_clear[i]) begin
               flag <= 1'b0;
            end
            // A load takes priority over an expiry on the same edge.
            if (hit) begin
               cnt    <= bus.load_value;
               reload <= bus.load_value;
               mode   <= bus.load_mode;
               state  <= (bus.load_value != '0) ? RUN : IDLE;
            end else if (step) begin
               if (cnt == WIDTH'(1)) begin
                  trig <= 1'b1;
                  flag <= 1'b1;
                  if (mode) begin
                     cnt <= reload;
                  end else begin
                     cnt   <= '0;
                     state <= IDLE;
                  end
               end else begin
                  cnt <= cnt - WIDTH'(1);
               end
            end
         end
      end

      assign bus.count[i*WIDTH +: WIDTH] = cnt;
      assign bus.trigger[i]              = trig;
      assign bus.irq[i]                  = flag;
      assign bus.busy[i]                 = (state == RUN);
   end

endmodule

`default_nettype wire
